max7219_serial_tx: RTL and testbench
====================================

// Module: max7219_serial_tx
// PURPOSE
//  Serial transmitter for the MAX7219 display driver. Consumes one 16-bit command word
//  (addr[11:8], data[7:0]) per handshake from the display sequencer in output_wrapper and
//  shifts it out MSB first on o_serial_dout/o_serial_clk, then pulses o_serial_load to latch it.
//  It is the last stage before the chip pins; the sequencer issues config and digit words through it.
// PARAMETERS
//  CLK_DIV  4   i_clk cycles per serial-clock half period (>=1; <1 is a elaboration error)
//  DATA_W   16  bits per word (fixed to 16 for MAX7219; other values unsupported)
// PORTS
//  i_clk          in   1       system clock (~50MHz), all logic on rising edge
//  i_reset        in   1       synchronous reset, active-high
//  i_stb          in   1       word valid; accepted only when o_busy==0
//  i_data         in   DATA_W  word to send, captured in the accept cycle
//  o_busy         out  1       transfer in progress; i_stb ignored while high
//  o_ack          out  1       1-cycle pulse: word latched into MAX7219
//  o_serial_dout  out  1       serial data, MSB first
//  o_serial_load  out  1       MAX7219 LOAD/CS; rising edge latches the word
//  o_serial_clk   out  1       serial clock; MAX7219 samples dout on rising edge
// BEHAVIOUR
//  - Reset (i_reset=1 at an edge): all outputs 0, FSM->IDLE, shift reg and counters 0.
//    Reset mid-transfer aborts: no ack, load never pulses, outputs 0 next cycle.
//  - All outputs registered; no combinational path from inputs to outputs.
//  - FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD.
//    IDLE:  i_stb=1 at edge T -> capture i_data, bit_cnt=15, ->SHIFT_LO; o_busy=1 from T+1.
//    SHIFT_LO: sclk=0, dout=shreg[15] valid for CLK_DIV cycles -> SHIFT_HI.
//    SHIFT_HI: sclk=1 for CLK_DIV cycles; at end: bit_cnt==0 -> LOAD, else shift left,
//              bit_cnt-1, ->SHIFT_LO. dout stable through entire high phase.
//    LOAD:  sclk=0, load=1 for CLK_DIV cycles, dout=0 -> IDLE with o_ack=1 for one cycle.
//  - Timing (stb accepted at T): busy high T+1..T+33*CLK_DIV; first sclk rise T+CLK_DIV+1;
//    16 sclk rises total; load high T+32*CLK_DIV+1..T+33*CLK_DIV; o_ack at T+33*CLK_DIV+1.
//    CLK_DIV=4: ack 133 cycles after accept.
//  - Ack cycle has o_busy=0; an i_stb in the ack cycle is accepted (back-to-back words,
//    no gap beyond the ack cycle).
//  - i_stb while busy: ignored, i_data not sampled, no queuing.
//  - Divider counter: $clog2(CLK_DIV)+1 bits, reloads CLK_DIV-1 on each phase change,
//    wraps only on phase change; CLK_DIV=1 gives sclk = i_clk/2.
//  - Idle levels: sclk=0, load=0, dout=0.
// STRUCTURE
//  - Shared include max7219_defs.vh: MAX7219 register addresses (NOOP 0x0, DIGIT0..7 0x1-0x8,
//    DECODE 0x9, INTENSITY 0xA, SCAN_LIMIT 0xB, SHUTDOWN 0xC, TEST 0xF), FSM state encodings.
//  - Single flat module; divider counter inline, no sub-modules needed.
// TESTING
//  1 Reset: hold i_reset 3 cycles with i_stb=1 -> all outputs 0, no transfer started.
//  2 Single word 0x0A05, CLK_DIV=4: bench SPI model sampling on sclk rise reads 0x0A05,
//    exactly 16 rises, load rises after 16th fall, o_ack exactly at T+133, busy T+1..T+132.
//  3 Back-to-back: 0x0C01 then 0x0900 issued in ack cycle -> both received in order,
//    second accept coincident with first ack, two acks 133 cycles apart.
//  4 Stb while busy: 0x0B07 accepted, 0xFFFF strobed at T+50 -> only 0x0B07 received,
//    one ack.
//  5 Reset mid-shift: assert i_reset at T+60 -> outputs 0 next cycle, no load pulse,
//    no ack; following word 0x0102 transfers cleanly.
//  6 CLK_DIV=1: word 0x8001 -> sclk period 2 cycles, ack at T+34, model reads 0x8001.

Source files
------------

// File: rtl/max7219_serial_tx_pkg.sv
// rtl/max7219_serial_tx_pkg.sv - MAX7219 register map, FSM states and command helper
// Shared by the serial transmitter and the display sequencer that feeds it.
package max7219_serial_tx_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_LOAD     = 2'd3
  } state_e;

  localparam logic [3:0] REG_NOOP       = 4'h0;
  localparam logic [3:0] REG_DIGIT0     = 4'h1;
  localparam logic [3:0] REG_DIGIT1     = 4'h2;
  localparam logic [3:0] REG_DIGIT2     = 4'h3;
  localparam logic [3:0] REG_DIGIT3     = 4'h4;
  localparam logic [3:0] REG_DIGIT4     = 4'h5;
  localparam logic [3:0] REG_DIGIT5     = 4'h6;
  localparam logic [3:0] REG_DIGIT6     = 4'h7;
  localparam logic [3:0] REG_DIGIT7     = 4'h8;
  localparam logic [3:0] REG_DECODE     = 4'h9;
  localparam logic [3:0] REG_INTENSITY  = 4'hA;
  localparam logic [3:0] REG_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN   = 4'hC;
  localparam logic [3:0] REG_TEST       = 4'hF;

  function automatic logic [WORD_W-1:0] mk_cmd(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/max7219_serial_tx.sv
// rtl/max7219_serial_tx.sv - MAX7219 serial word transmitter (MSB first, LOAD strobe, ack)
// Accepts one 16-bit command per handshake and drives the chip's DIN/CLK/LOAD pins.
module max7219_serial_tx
  import max7219_serial_tx_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = WORD_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stb,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_ack,
  output logic              o_serial_dout,
  output logic              o_serial_load,
  output logic              o_serial_clk
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("CLK_DIV must be at least 1");
  end
  if (DATA_W != 16) begin : g_bad_data_w
    $error("DATA_W must be 16 for the MAX7219");
  end

  localparam int                CNT_W      = $clog2(CLK_DIV) + 1;
  localparam int                BIT_W      = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  DIV_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic              busy_q, busy_d;
  logic              ack_q, ack_d;
  logic              load_q, load_d;
  logic              sclk_q, sclk_d;
  logic              phase_end;

  assign phase_end = (div_q == '0);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    load_d    = load_q;
    sclk_d    = sclk_q;

    case (state_q)
      ST_IDLE: begin
        if (i_stb) begin
          shreg_d   = i_data;
          bit_cnt_d = LAST_BIT;
          div_d     = DIV_RELOAD;
          busy_d    = 1'b1;
          sclk_d    = 1'b0;
          load_d    = 1'b0;
          state_d   = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (phase_end) begin
          div_d   = DIV_RELOAD;
          sclk_d  = 1'b1;
          state_d = ST_SHIFT_HI;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_end) begin
          div_d   = DIV_RELOAD;
          sclk_d  = 1'b0;
          // Shifting on the last bit too leaves the register all-zero, so DIN idles low.
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          if (bit_cnt_q == '0) begin
            load_d  = 1'b1;
            state_d = ST_LOAD;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
            state_d   = ST_SHIFT_LO;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_LOAD: begin
        if (phase_end) begin
          load_d  = 1'b0;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      load_q    <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      load_q    <= load_d;
      sclk_q    <= sclk_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_ack         = ack_q;
  assign o_serial_dout = shreg_q[DATA_W-1];
  assign o_serial_load = load_q;
  assign o_serial_clk  = sclk_q;

endmodule

// File: tb/tb_max7219_serial_tx.sv
// tb/tb_max7219_serial_tx.sv - scoreboard bench for max7219_serial_tx (CLK_DIV 4 and 1)
// Instance 0 uses CLK_DIV=4, instance 1 uses CLK_DIV=1; an SPI model decodes both.
module tb_max7219_serial_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  stb = 2'b00;
  logic [15:0] din [2];
  logic [1:0]  busy, ack, dout, load, sclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  logic [15:0] bits [2];
  logic [15:0] word [2];
  int rises [2]       = '{0, 0};
  int first_rise [2]  = '{0, 0};
  int second_rise [2] = '{0, 0};
  int load_first [2]  = '{0, 0};
  int load_last [2]   = '{0, 0};
  int busy_start [2]  = '{0, 0};
  int busy_end [2]    = '{0, 0};
  int load_cnt [2]    = '{0, 0};
  int ack_cnt [2]     = '{0, 0};
  logic [1:0] sclk_p = 2'b00, load_p = 2'b00, busy_p = 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  max7219_serial_tx #(.CLK_DIV(4)) u_dut4 (
    .i_clk(clk), .i_reset(rst), .i_stb(stb[0]), .i_data(din[0]),
    .o_busy(busy[0]), .o_ack(ack[0]), .o_serial_dout(dout[0]),
    .o_serial_load(load[0]), .o_serial_clk(sclk[0])
  );

  max7219_serial_tx #(.CLK_DIV(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_stb(stb[1]), .i_data(din[1]),
    .o_busy(busy[1]), .o_ack(ack[1]), .o_serial_dout(dout[1]),
    .o_serial_load(load[1]), .o_serial_clk(sclk[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // SPI slave model: shift on sclk rise, capture on load rise, retire on ack.
  always @(negedge clk) begin
    logic [15:0] e;
    for (int i = 0; i < 2; i++) begin
      if (busy[i] && !busy_p[i]) begin
        busy_start[i] = cyc;
        bits[i]       = 16'h0;
        rises[i]      = 0;
      end
      if (!busy[i] && busy_p[i]) busy_end[i] = cyc - 1;
      if (sclk[i] && !sclk_p[i]) begin
        bits[i] = {bits[i][14:0], dout[i]};
        rises[i]++;
        if (rises[i] == 1) first_rise[i] = cyc;
        if (rises[i] == 2) second_rise[i] = cyc;
      end
      if (load[i] && !load_p[i]) begin
        check("rises_before_load", rises[i], 16);
        word[i]       = bits[i];
        load_first[i] = cyc;
        load_cnt[i]++;
      end
      if (!load[i] && load_p[i]) load_last[i] = cyc - 1;
      if (ack[i]) begin
        ack_cnt[i]++;
        if (i == 0) begin
          if (exp_q0.size() == 0) begin
            check("unexpected_ack0", 1, 0);
          end else begin
            e = exp_q0.pop_front();
            check("rx_word0", word[i], e);
          end
        end else begin
          if (exp_q1.size() == 0) begin
            check("unexpected_ack1", 1, 0);
          end else begin
            e = exp_q1.pop_front();
            check("rx_word1", word[i], e);
          end
        end
      end
      sclk_p[i] = sclk[i];
      load_p[i] = load[i];
      busy_p[i] = busy[i];
    end
  end

  task automatic send(input int i, input logic [15:0] w, input bit push, output int acc);
    @(negedge clk);
    stb[i] = 1'b1;
    din[i] = w;
    if (push) begin
      if (i == 0) exp_q0.push_back(w);
      else        exp_q1.push_back(w);
    end
    @(negedge clk);
    stb[i] = 1'b0;
    acc    = cyc;
    check("accept_busy", busy[i], 1);
  endtask

  task automatic wait_ack(input int i, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (ack[i]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL ack_wait: observed no ack expected ack within %0d cycles", budget);
    end
  endtask

  initial begin
    int a, a2, k1, k2, acks0, loads0;
    din[0] = 16'h0;
    din[1] = 16'h0;

    // Reset held with strobe asserted: nothing may start.
    rst    = 1'b1;
    stb    = 2'b11;
    din[0] = 16'h0A05;
    din[1] = 16'h0A05;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check("reset_outputs", {busy[i], ack[i], dout[i], load[i], sclk[i]}, 0);
    rst = 1'b0;
    stb = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      check("idle_after_reset", {busy[i], ack[i], dout[i], load[i], sclk[i]}, 0);

    // Single word, full timing profile at CLK_DIV=4.
    send(0, 16'h0A05, 1'b1, a);
    wait_ack(0, 200, k1);
    @(negedge clk);
    check("ack_latency", k1 - a, 132);
    check("busy_first", busy_start[0], a);
    check("busy_last", busy_end[0], a + 131);
    check("first_sclk_rise", first_rise[0], a + 4);
    check("sclk_period", second_rise[0] - first_rise[0], 8);
    check("load_first", load_first[0], a + 128);
    check("load_last", load_last[0], a + 131);
    check("idle_dout", dout[0], 0);

    // Back-to-back: second strobe sits in the ack cycle.
    send(0, 16'h0C01, 1'b1, a);
    wait_ack(0, 200, k1);
    stb[0] = 1'b1;
    din[0] = 16'h0900;
    exp_q0.push_back(16'h0900);
    @(negedge clk);
    stb[0] = 1'b0;
    a2 = cyc;
    check("b2b_accept_busy", busy[0], 1);
    check("b2b_ack_single", ack[0], 0);
    wait_ack(0, 200, k2);
    check("ack_spacing", k2 - k1, 133);
    check("b2b_latency", k2 - a2, 132);

    // Strobe while busy is dropped.
    @(negedge clk);
    acks0  = ack_cnt[0];
    loads0 = load_cnt[0];
    send(0, 16'h0B07, 1'b1, a);
    repeat (48) @(negedge clk);
    stb[0] = 1'b1;
    din[0] = 16'hFFFF;
    @(negedge clk);
    stb[0] = 1'b0;
    check("busy_during_stray_stb", busy[0], 1);
    wait_ack(0, 200, k1);
    check("stray_latency", k1 - a, 132);
    repeat (150) @(negedge clk);
    check("single_ack", ack_cnt[0] - acks0, 1);
    check("single_load", load_cnt[0] - loads0, 1);

    // Reset mid-shift aborts silently.
    acks0  = ack_cnt[0];
    loads0 = load_cnt[0];
    send(0, 16'h0A0F, 1'b0, a);
    repeat (58) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {busy[0], ack[0], dout[0], load[0], sclk[0]}, 0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("abort_no_ack", ack_cnt[0] - acks0, 0);
    check("abort_no_load", load_cnt[0] - loads0, 0);
    send(0, 16'h0102, 1'b1, a);
    wait_ack(0, 200, k1);
    check("post_abort_latency", k1 - a, 132);

    // CLK_DIV=1 instance.
    send(1, 16'h8001, 1'b1, a);
    wait_ack(1, 100, k1);
    @(negedge clk);
    check("div1_ack_latency", k1 - a, 33);
    check("div1_first_rise", first_rise[1], a + 1);
    check("div1_sclk_period", second_rise[1] - first_rise[1], 2);
    check("div1_load_first", load_first[1], a + 32);

    repeat (5) @(negedge clk);
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
